integration_scheduler: RTL and testbench
========================================

Name: integration_scheduler

Overview:
Clock-domain controller that sequences the correlator's integration windows and frame hand-off to the UART serializer. It decodes host command bytes from the UART receiver and runs a programmable-length integration timer. Each window it issues a latch strobe to snapshot pulse/correlation counters, then a clear strobe to restart them. It also starts transmission when the serializer is free and counts dropped frames, so integration timing no longer depends on the UART bit clock.

Parameters:
TIMER_WIDTH, 32, width of integration period register and timer
DEFAULT_PERIOD, 50000000, period in clk cycles after reset (1 s at 50 MHz)
MIN_PERIOD, 4, smallest accepted period; smaller writes are clamped up

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rx_data  input  8  received command byte; [3:0] opcode, [7:4] argument
rx_valid  input  1  one-cycle pulse, rx_data valid (already in clk domain)
tx_busy  input  1  serializer busy with a frame
latch  output  1  one-cycle strobe: snapshot counters into tx buffer
counter_clear  output  1  one-cycle strobe: zero all pulse/correlation counters
tx_start  output  1  one-cycle strobe: begin frame transmission
capturing  output  1  high while in RUN
active_line  output  4  selected LED pair index
leds  output  32  LED/status word
baud_rate  output  4  baud divider shift for the UART clock generator
period  output  TIMER_WIDTH  active integration period
frame_count  output  16  frames handed to serializer, wraps
overrun_count  output  8  frames dropped due to tx_busy, saturates at 255

Behaviour:
- Reset (async, reset_n low): state IDLE; all strobes 0; capturing 0; active_line 0; leds 0; baud_rate 0; period and shadow period = DEFAULT_PERIOD; timer 0; frame_count 0; overrun_count 0.
- Commands act only in the cycle rx_valid=1; unknown opcodes are ignored:
  - 1 SET_ACTIVE_LINE: active_line <= arg.
  - 2 SET_LEDS: leds[active_line*2+:2] <= arg[1:0].
  - 3 SET_BAUD_RATE: baud_rate <= arg.
  - 4 PERIOD_NIBBLE: shadow <= {shadow[TIMER_WIDTH-5:0], arg}.
  - 5 PERIOD_COMMIT: pending <= 1.
  - 6 CLEAR_STATS: frame_count, overrun_count <= 0.
  - 13 ENABLE_CAPTURE: arg[0]=1 requests start; arg[0]=0 requests stop.
- Period load: when pending=1, period <= max(shadow, MIN_PERIOD) in IDLE immediately, or in RUN at the next latch cycle; pending then clears. A period change never truncates a running window.
- FSM states: IDLE, ARM, RUN.
  - IDLE: start -> ARM.
  - ARM (1 cycle): counter_clear=1, timer <= 0 -> RUN.
  - RUN: timer increments each cycle. When timer==period-1: latch=1, timer <= 0. The following cycle: counter_clear=1. Steady state gives exactly one latch every period cycles.
  - RUN, stop command: -> IDLE next cycle; counter_clear=1 in that cycle; no latch, partial window discarded.
  - Start in ARM/RUN and stop in IDLE are ignored.
- Transmission: tx_busy is sampled in the latch cycle.
  - If 0: tx_start=1 in the next cycle, coincident with counter_clear; frame_count++.
  - If 1: no tx_start; overrun_count++ (saturating).
- If stop arrives in the latch cycle, latch and that cycle's tx decision still complete; the FSM enters IDLE on the following cycle, which also carries the clear and the tx_start.
- reset_n asserted mid-window: everything returns to reset values asynchronously; no strobe glitches on deassertion.
- All outputs are registered.

Test Plan:
- Reset: reset_n low with rx traffic -> all outputs at reset values; period=50000000; no strobes.
- Period program: DEFAULT_PERIOD=16; bytes 0x04,0x04,0x05 (shadow 0x00..0) then 0xA4, 0x05 -> period=10. Then 0x1D -> counter_clear 1 cycle; latch at 10-cycle spacing; counter_clear and tx_start the cycle after each latch; frame_count increments per latch.
- Clamp: commit shadow 0x2 -> period=4; latch every 4 cycles.
- Overrun: tx_busy held 1 across 3 latches -> no tx_start; overrun_count=3; frame_count unchanged. Hold tx_busy across 300 latches -> overrun_count=255.
- Mid-window changes: in RUN with period 10, commit 20 at timer=3 -> current window still latches at 10, next at 20. Send 0x0D at timer=5 -> IDLE, one counter_clear, no latch. Repeat the stop in the latch cycle -> latch, then clear and tx_start, then IDLE.
- LED/baud: 0x31 then 0x32 -> leds[7:6]=2'b11. 0x53 -> baud_rate=5. Async reset pulse mid-RUN -> IDLE, capturing 0.

Source files
------------

// File: rtl/integration_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : integration_scheduler
// Brief    : Integration window sequencer: host command decode, programmable
//            window timer, latch/clear strobes and UART frame hand-off.
// Revision : 1.0 - initial release
// ============================================================================
module integration_scheduler #(
    parameter int TIMER_WIDTH    = 32,
    parameter int DEFAULT_PERIOD = 50000000,
    parameter int MIN_PERIOD     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_busy,
    output logic                   latch,
    output logic                   counter_clear,
    output logic                   tx_start,
    output logic                   capturing,
    output logic [3:0]             active_line,
    output logic [31:0]            leds,
    output logic [3:0]             baud_rate,
    output logic [TIMER_WIDTH-1:0] period,
    output logic [15:0]            frame_count,
    output logic [7:0]             overrun_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;

    localparam logic [3:0] c_OP_LINE    = 4'd1;
    localparam logic [3:0] c_OP_LEDS    = 4'd2;
    localparam logic [3:0] c_OP_BAUD    = 4'd3;
    localparam logic [3:0] c_OP_NIBBLE  = 4'd4;
    localparam logic [3:0] c_OP_COMMIT  = 4'd5;
    localparam logic [3:0] c_OP_CLEAR   = 4'd6;
    localparam logic [3:0] c_OP_CAPTURE = 4'd13;

    localparam logic [TIMER_WIDTH-1:0] c_DEFAULT_PERIOD = TIMER_WIDTH'(DEFAULT_PERIOD);
    localparam logic [TIMER_WIDTH-1:0] c_MIN_PERIOD     = TIMER_WIDTH'(MIN_PERIOD);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [TIMER_WIDTH-1:0] w_timer_next;
    logic [TIMER_WIDTH-1:0] r_period;
    logic [TIMER_WIDTH-1:0] w_period_next;
    logic [TIMER_WIDTH-1:0] w_period_last;
    logic [TIMER_WIDTH-1:0] r_shadow;
    logic [TIMER_WIDTH-1:0] w_shadow_clamped;
    logic                   r_pending;
    logic                   w_load;
    logic                   r_latch;
    logic                   r_clear;
    logic                   r_tx_start;
    logic                   r_capturing;
    logic                   w_latch_next;
    logic                   w_clear_next;
    logic                   w_tx_start_next;
    logic                   w_capturing_next;
    logic [3:0]             r_active_line;
    logic [3:0]             r_baud_rate;
    logic [31:0]            r_leds;
    logic [15:0]            r_frame_count;
    logic [7:0]             r_overrun_count;
    logic [3:0]             w_opcode;
    logic [3:0]             w_arg;
    logic                   w_start;
    logic                   w_stop;

    assign w_opcode = rx_data[3:0];
    assign w_arg    = rx_data[7:4];
    assign w_start  = rx_valid && (w_opcode == c_OP_CAPTURE) &&  w_arg[0];
    assign w_stop   = rx_valid && (w_opcode == c_OP_CAPTURE) && !w_arg[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_state_next = c_ARM;
            c_ARM:   w_state_next = c_RUN;
            c_RUN:   if (w_stop) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // A committed period lands only on a window boundary, so a running window is never cut short.
    assign w_shadow_clamped = (r_shadow < c_MIN_PERIOD) ? c_MIN_PERIOD : r_shadow;
    assign w_load           = r_pending && ((r_state == c_IDLE) || r_latch);
    assign w_period_next    = w_load ? w_shadow_clamped : r_period;
    assign w_period_last    = w_period_next - 1'b1;
    assign w_timer_next     = ((r_state == c_RUN) && (w_state_next == c_RUN) && !r_latch) ?
                              r_timer + 1'b1 : '0;

    always_comb begin
        w_latch_next     = (w_state_next == c_RUN) && (w_timer_next == w_period_last);
        w_clear_next     = ((r_state == c_IDLE) && w_start) || r_latch ||
                           ((r_state == c_RUN) && w_stop);
        w_tx_start_next  = r_latch && !tx_busy;
        w_capturing_next = (w_state_next == c_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_latch         <= 1'b0;
            r_clear         <= 1'b0;
            r_tx_start      <= 1'b0;
            r_capturing     <= 1'b0;
            r_timer         <= '0;
            r_period        <= c_DEFAULT_PERIOD;
            r_shadow        <= c_DEFAULT_PERIOD;
            r_pending       <= 1'b0;
            r_active_line   <= 4'd0;
            r_leds          <= 32'd0;
            r_baud_rate     <= 4'd0;
            r_frame_count   <= 16'd0;
            r_overrun_count <= 8'd0;
        end else begin
            r_latch     <= w_latch_next;
            r_clear     <= w_clear_next;
            r_tx_start  <= w_tx_start_next;
            r_capturing <= w_capturing_next;
            r_timer     <= w_timer_next;
            r_period    <= w_period_next;

            if (rx_valid && (w_opcode == c_OP_COMMIT)) begin
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end

            if (rx_valid) begin
                case (w_opcode)
                    c_OP_LINE:   r_active_line <= w_arg;
                    c_OP_LEDS:   r_leds[{r_active_line, 1'b0} +: 2] <= w_arg[1:0];
                    c_OP_BAUD:   r_baud_rate <= w_arg;
                    c_OP_NIBBLE: r_shadow <= {r_shadow[TIMER_WIDTH-5:0], w_arg};
                    default:     ;
                endcase
            end

            // The frame decision uses tx_busy as seen during the latch cycle.
            if (rx_valid && (w_opcode == c_OP_CLEAR)) begin
                r_frame_count   <= 16'd0;
                r_overrun_count <= 8'd0;
            end else if (r_latch) begin
                if (!tx_busy) begin
                    r_frame_count <= r_frame_count + 1'b1;
                end else if (r_overrun_count != 8'hFF) begin
                    r_overrun_count <= r_overrun_count + 1'b1;
                end
            end
        end
    end

    assign latch         = r_latch;
    assign counter_clear = r_clear;
    assign tx_start      = r_tx_start;
    assign capturing     = r_capturing;
    assign active_line   = r_active_line;
    assign leds          = r_leds;
    assign baud_rate     = r_baud_rate;
    assign period        = r_period;
    assign frame_count   = r_frame_count;
    assign overrun_count = r_overrun_count;

endmodule
`default_nettype wire

// File: tb/tb_integration_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_integration_scheduler
// Brief    : Bench for integration_scheduler: command vector table, directed
//            window sequences and random traffic against a window-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_integration_scheduler;

    localparam int TW    = 12;
    localparam int DEF_P = 16;
    localparam int MIN_P = 4;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic [7:0]    rx_data  = 8'd0;
    logic          rx_valid = 1'b0;
    logic          tx_busy  = 1'b0;
    logic          latch;
    logic          counter_clear;
    logic          tx_start;
    logic          capturing;
    logic [3:0]    active_line;
    logic [31:0]   leds;
    logic [3:0]    baud_rate;
    logic [TW-1:0] period;
    logic [15:0]   frame_count;
    logic [7:0]    overrun_count;

    always #5 clk = ~clk;

    integration_scheduler #(
        .TIMER_WIDTH   (TW),
        .DEFAULT_PERIOD(DEF_P),
        .MIN_PERIOD    (MIN_P)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_busy      (tx_busy),
        .latch        (latch),
        .counter_clear(counter_clear),
        .tx_start     (tx_start),
        .capturing    (capturing),
        .active_line  (active_line),
        .leds         (leds),
        .baud_rate    (baud_rate),
        .period       (period),
        .frame_count  (frame_count),
        .overrun_count(overrun_count)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [3:0]  line;
        logic [31:0] leds;
        logic [3:0]  baud;
    } vec_t;

    vec_t vecs[11];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: windows are tracked as absolute cycle numbers.
    bit          m_active;
    bit          m_pending;
    int          m_arm;
    int          m_next_latch;
    int          m_period;
    int          m_shadow;
    int          m_line;
    int          m_baud;
    int          m_frames;
    int          m_ovr;
    logic [31:0] m_leds;
    bit          e_latch;
    bit          e_clear;
    bit          e_tx;

    int latch_log[$];
    int clear_log[$];
    int tx_log[$];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampf(input int v);
        return (v < MIN_P) ? MIN_P : v;
    endfunction

    task automatic model_reset();
        m_active = 0; m_pending = 0; m_arm = 0; m_next_latch = -1;
        m_period = DEF_P; m_shadow = DEF_P;
        m_line = 0; m_baud = 0; m_frames = 0; m_ovr = 0; m_leds = '0;
        e_latch = 0; e_clear = 0; e_tx = 0;
    endtask

    // Inputs v/d/busy were presented during cycle cyc-1; compute expectations for cycle cyc.
    task automatic model_step(input bit v, input logic [7:0] d, input bit busy);
        bit prev_latch;
        bit was_idle;
        int arg;
        prev_latch = e_latch;
        was_idle   = !m_active;
        arg        = int'(d[7:4]);
        e_clear = 0;
        e_tx    = 0;
        if (prev_latch) begin
            e_clear = 1;
            if (!busy) begin
                e_tx = 1;
                m_frames = (m_frames + 1) % 65536;
            end else if (m_ovr < 255) begin
                m_ovr++;
            end
            if (m_pending) begin
                m_period  = clampf(m_shadow);
                m_pending = 0;
            end
            m_next_latch = (cyc - 1) + m_period;
        end else if (was_idle && m_pending) begin
            m_period  = clampf(m_shadow);
            m_pending = 0;
        end
        if (v) begin
            case (int'(d[3:0]))
                1: m_line = arg;
                2: m_leds[m_line*2 +: 2] = d[5:4];
                3: m_baud = arg;
                4: m_shadow = ((m_shadow << 4) | arg) & ((1 << TW) - 1);
                5: m_pending = 1;
                6: begin m_frames = 0; m_ovr = 0; end
                13: begin
                    if (d[4] && was_idle) begin
                        m_active     = 1;
                        m_arm        = cyc;
                        e_clear      = 1;
                        m_next_latch = cyc + m_period;
                    end else if (!d[4] && m_active && (cyc - 1) > m_arm) begin
                        m_active = 0;
                        e_clear  = 1;
                    end
                end
                default: ;
            endcase
        end
        e_latch = m_active && (cyc == m_next_latch);
    endtask

    task automatic check_all();
        chk("latch",         latch,         e_latch);
        chk("counter_clear", counter_clear, e_clear);
        chk("tx_start",      tx_start,      e_tx);
        chk("capturing",     capturing,     m_active && (cyc > m_arm));
        chk("active_line",   active_line,   m_line);
        chk("leds",          leds,          m_leds);
        chk("baud_rate",     baud_rate,     m_baud);
        chk("period",        period,        m_period);
        chk("frame_count",   frame_count,   m_frames);
        chk("overrun_count", overrun_count, m_ovr);
    endtask

    task automatic step();
        bit         rst_s;
        bit         v_s;
        bit         b_s;
        logic [7:0] d_s;
        @(posedge clk);
        rst_s = reset_n;
        v_s   = rx_valid;
        d_s   = rx_data;
        b_s   = tx_busy;
        #1;
        cyc++;
        if (!rst_s) model_reset();
        else        model_step(v_s, d_s, b_s);
        check_all();
        if (latch)         latch_log.push_back(cyc);
        if (counter_clear) clear_log.push_back(cyc);
        if (tx_start)      tx_log.push_back(cyc);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic wait_latch(input int bound);
        int n;
        n = 0;
        step();
        while (!latch && n < bound) begin
            step();
            n++;
        end
        chk("wait_latch", latch, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, base, n0, c0, cb, f0, o0;
        int ops[12];
        int op, arg;
        ops = '{1, 2, 3, 4, 4, 4, 4, 5, 5, 6, 13, 9};

        vecs[0]  = '{8'h31, 4'd3,  32'h0000_0000, 4'd0};
        vecs[1]  = '{8'h32, 4'd3,  32'h0000_00C0, 4'd0};
        vecs[2]  = '{8'h53, 4'd3,  32'h0000_00C0, 4'd5};
        vecs[3]  = '{8'h01, 4'd0,  32'h0000_00C0, 4'd5};
        vecs[4]  = '{8'h12, 4'd0,  32'h0000_00C1, 4'd5};
        vecs[5]  = '{8'hF1, 4'd15, 32'h0000_00C1, 4'd5};
        vecs[6]  = '{8'h32, 4'd15, 32'hC000_00C1, 4'd5};
        vecs[7]  = '{8'h07, 4'd15, 32'hC000_00C1, 4'd5};
        vecs[8]  = '{8'h02, 4'd15, 32'h0000_00C1, 4'd5};
        vecs[9]  = '{8'h23, 4'd15, 32'h0000_00C1, 4'd2};
        vecs[10] = '{8'hFF, 4'd15, 32'h0000_00C1, 4'd2};

        model_reset();

        // Reset held with live rx traffic.
        for (int i = 0; i < 4; i++) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
            tx_busy  = 1'($urandom);
            step();
        end
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        chk("rst_period",   period, DEF_P);
        chk("rst_capture",  capturing, 0);
        chk("rst_strobes",  {latch, counter_clear, tx_start}, 0);
        chk("rst_leds",     leds, 0);
        chk("rst_frames",   frame_count, 0);
        chk("rst_overrun",  overrun_count, 0);
        reset_n = 1'b1;
        idle(2);

        // LED / baud command table.
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].cmd);
            chk($sformatf("vec%0d_line", i), active_line, vecs[i].line);
            chk($sformatf("vec%0d_leds", i), leds,        vecs[i].leds);
            chk($sformatf("vec%0d_baud", i), baud_rate,   vecs[i].baud);
        end

        // Period programming in IDLE, including clamp of a zero shadow.
        send(8'h04); send(8'h04); send(8'h05);
        idle(2);
        chk("period_clamp_zero", period, 4);
        send(8'hA4); send(8'h05);
        idle(2);
        chk("period_prog_10", period, 10);

        // Start capture: one ARM clear, then a latch every 10 cycles.
        latch_log.delete(); clear_log.delete(); tx_log.delete();
        f0 = frame_count;
        send(8'h1D);
        s = cyc;
        chk("arm_clear", counter_clear, 1);
        chk("arm_not_capturing", capturing, 0);
        idle(33);
        chk("run_latches", latch_log.size(), 3);
        chk("run_latch0", latch_log[0], s + 10);
        chk("run_latch1", latch_log[1], s + 20);
        chk("run_latch2", latch_log[2], s + 30);
        chk("run_clears", clear_log.size(), 4);
        chk("run_tx0", tx_log[0], s + 11);
        chk("run_tx_count", tx_log.size(), 3);
        chk("run_frames", frame_count, f0 + 3);

        // Clamp while running: commit 2 -> period 4 at the next boundary.
        send(8'h04); send(8'h04); send(8'h24); send(8'h05);
        latch_log.delete();
        idle(40);
        chk("clamp_period", period, 4);
        chk("clamp_spacing", latch_log[latch_log.size()-1] - latch_log[latch_log.size()-2], 4);

        // Overrun: busy across 3 latches, then saturation.
        if (latch) step();
        tx_busy = 1'b1;
        o0 = overrun_count;
        f0 = frame_count;
        tx_log.delete();
        wait_latch(20); wait_latch(20); wait_latch(20);
        step();
        chk("ovr_count3", overrun_count, o0 + 3);
        chk("ovr_frames_held", frame_count, f0);
        chk("ovr_no_tx", tx_log.size(), 0);
        idle(1250);
        chk("ovr_saturate", overrun_count, 255);
        tx_busy = 1'b0;
        send(8'h06);
        chk("clear_stats_frames", frame_count, 0);
        chk("clear_stats_overrun", overrun_count, 0);

        // Back to period 10, then commit 20 at timer 3 of a window.
        send(8'h04); send(8'h04); send(8'hA4); send(8'h05);
        wait_latch(20);
        wait_latch(20);
        base = cyc;
        step();
        send(8'h04); send(8'h14); send(8'h44); send(8'h05);
        wait_latch(30);
        chk("no_truncate", cyc, base + 10);
        wait_latch(40);
        chk("new_period_20", cyc, base + 30);

        // Stop at timer 5: one clear, no latch.
        base = cyc;
        idle(6);
        cb = clear_log.size();
        send(8'h0D);
        chk("stop_idle", capturing, 0);
        chk("stop_clear", counter_clear, 1);
        chk("stop_at", cyc, base + 7);
        n0 = latch_log.size();
        c0 = clear_log.size();
        chk("stop_one_clear", c0 - cb, 1);
        idle(30);
        chk("stop_no_latch", latch_log.size(), n0);
        chk("stop_no_more_clear", clear_log.size(), c0);

        // Stop issued in the latch cycle.
        send(8'h1D);
        wait_latch(40);
        send(8'h0D);
        chk("stoplat_clear", counter_clear, 1);
        chk("stoplat_tx", tx_start, 1);
        chk("stoplat_idle", capturing, 0);
        n0 = latch_log.size();
        idle(45);
        chk("stoplat_no_latch", latch_log.size(), n0);

        // Asynchronous reset mid-window.
        send(8'h1D);
        idle(7);
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset_capture", capturing, 0);
        chk("areset_strobes", {latch, counter_clear, tx_start}, 0);
        chk("areset_period", period, DEF_P);
        chk("areset_line", active_line, 0);
        chk("areset_frames", frame_count, 0);
        idle(2);
        reset_n = 1'b1;
        idle(5);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                op  = ops[$urandom_range(0, 11)];
                arg = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0;
                if (op == 13 || op == 1 || op == 2) arg = int'($urandom_range(0, 15));
                rx_data  = {4'(arg), 4'(op)};
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) tx_busy = ~tx_busy;
            step();
        end
        rx_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
